// File: rtl/trap_ret_seq_if.sv
// Decoder-to-sequencer bundle: decoded trap sources in, selected trap and WFI stall out.
interface trap_ret_seq_if;
    logic        EcallFaultM;
    logic        BreakpointFaultM;
    logic        IllegalInstrFaultM;
    logic        mretM;
    logic        sretM;
    logic        wfiM;
    logic [11:0] InterruptPendingM;
    logic        TrapM;
    logic        InterruptM;
    logic [3:0]  CauseM;
    logic        TrapToSM;
    logic        WFIStallM;

    modport master (
        output EcallFaultM, BreakpointFaultM, IllegalInstrFaultM,
        output mretM, sretM, wfiM, InterruptPendingM,
        input  TrapM, InterruptM, CauseM, TrapToSM, WFIStallM
    );

    modport slave (
        input  EcallFaultM, BreakpointFaultM, IllegalInstrFaultM,
        input  mretM, sretM, wfiM, InterruptPendingM,
        output TrapM, InterruptM, CauseM, TrapToSM, WFIStallM
    );
endinterface

// File: rtl/trap_ret_seq.sv
// Privilege-state sequencer: trap selection and delegation, mstatus trap stack,
// mret/sret unwinding and the WFI sleep/timeout state machine.
module trap_ret_seq #(
    parameter bit S_SUPPORTED     = 1'b1,
    parameter bit U_SUPPORTED     = 1'b1,
    parameter int WFI_TIMEOUT_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallW,
    trap_ret_seq_if.slave dec,
    input  logic [15:0] MEDELEG,
    input  logic [11:0] MIDELEG,
    input  logic        STATUS_TW,
    input  logic        WriteMSTATUSM,
    input  logic [12:0] CSRWriteValM,
    output logic [1:0]  PrivilegeModeW,
    output logic        STATUS_MIE,
    output logic        STATUS_SIE,
    output logic        STATUS_MPIE,
    output logic        STATUS_SPIE,
    output logic        STATUS_SPP,
    output logic [1:0]  STATUS_MPP
);
    localparam logic [1:0] PRIV_U  = 2'b00;
    localparam logic [1:0] PRIV_S  = 2'b01;
    localparam logic [1:0] PRIV_M  = 2'b11;
    localparam logic [1:0] MPP_RET = U_SUPPORTED ? PRIV_U : PRIV_M;

    typedef enum logic {Run = 1'b0, Sleep = 1'b1} wfiState_t;

    wfiState_t                wfiState, wfiNext;
    logic [WFI_TIMEOUT_BIT:0] wfiCount;
    logic                     wfiTimeout, wfiStall;

    logic [11:0] intDeleg, intElig;
    logic [15:0] midelegExt;
    logic        enM, enS, intTaken;
    logic [3:0]  intCause;
    logic        trapM, interruptM, trapToSM, delegBit;
    logic [3:0]  causeM;
    logic [1:0]  wrMpp;
    logic        mppLegal;
    logic        unusedCsrBits;

    // Delegated interrupts are gated by the S-level enable and never fire from M.
    assign intDeleg = MIDELEG & {12{S_SUPPORTED}};
    assign enM      = (PrivilegeModeW != PRIV_M) | STATUS_MIE;
    assign enS      = (PrivilegeModeW == PRIV_U) | ((PrivilegeModeW == PRIV_S) & STATUS_SIE);
    assign intElig  = dec.InterruptPendingM & ((~intDeleg & {12{enM}}) | (intDeleg & {12{enS}}));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        intTaken = 1'b1;
        intCause = 4'd0;
        if      (intElig[11]) intCause = 4'd11;
        else if (intElig[3])  intCause = 4'd3;
        else if (intElig[7])  intCause = 4'd7;
        else if (intElig[9])  intCause = 4'd9;
        else if (intElig[1])  intCause = 4'd1;
        else if (intElig[5])  intCause = 4'd5;
        else                  intTaken = 1'b0;
    end

    always_comb begin
        trapM      = 1'b1;
        interruptM = 1'b0;
        causeM     = 4'd0;
        if (intTaken) begin
            interruptM = 1'b1;
            causeM     = intCause;
        end else if (dec.BreakpointFaultM) begin
            causeM = 4'd3;
        end else if (dec.IllegalInstrFaultM | wfiTimeout) begin
            causeM = 4'd2;
        end else if (dec.EcallFaultM) begin
            causeM = {2'b10, PrivilegeModeW};
        end else begin
            trapM = 1'b0;
        end
    end

    assign midelegExt = {4'b0000, MIDELEG};
    assign delegBit   = interruptM ? midelegExt[causeM] : MEDELEG[causeM];
    assign trapToSM   = trapM & S_SUPPORTED & (PrivilegeModeW != PRIV_M) & delegBit;

    assign dec.TrapM      = trapM;
    assign dec.InterruptM = interruptM;
    assign dec.CauseM     = causeM;
    assign dec.TrapToSM   = trapToSM;
    assign dec.WFIStallM  = wfiStall;

    // An unimplemented MPP encoding in a CSR write leaves the field untouched.
    assign wrMpp    = CSRWriteValM[12:11];
    assign mppLegal = (wrMpp == PRIV_M) | ((wrMpp == PRIV_S) & S_SUPPORTED) |
                      ((wrMpp == PRIV_U) & U_SUPPORTED);
    assign unusedCsrBits = ^{CSRWriteValM[10:9], CSRWriteValM[6], CSRWriteValM[4],
                             CSRWriteValM[2], CSRWriteValM[0]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PrivilegeModeW <= PRIV_M;
            STATUS_MIE     <= 1'b0;
            STATUS_SIE     <= 1'b0;
            STATUS_MPIE    <= 1'b0;
            STATUS_SPIE    <= 1'b0;
            STATUS_SPP     <= 1'b0;
            STATUS_MPP     <= MPP_RET;
        end else if (!StallW) begin
            if (trapM & trapToSM) begin
                STATUS_SPP     <= PrivilegeModeW[0];
                STATUS_SPIE    <= STATUS_SIE;
                STATUS_SIE     <= 1'b0;
                PrivilegeModeW <= PRIV_S;
            end else if (trapM) begin
                STATUS_MPP     <= PrivilegeModeW;
                STATUS_MPIE    <= STATUS_MIE;
                STATUS_MIE     <= 1'b0;
                PrivilegeModeW <= PRIV_M;
            end else if (dec.mretM) begin
                PrivilegeModeW <= STATUS_MPP;
                STATUS_MIE     <= STATUS_MPIE;
                STATUS_MPIE    <= 1'b1;
                STATUS_MPP     <= MPP_RET;
            end else if (dec.sretM) begin
                PrivilegeModeW <= {1'b0, STATUS_SPP};
                STATUS_SIE     <= STATUS_SPIE;
                STATUS_SPIE    <= S_SUPPORTED;
                STATUS_SPP     <= 1'b0;
            end else if (WriteMSTATUSM) begin
                STATUS_MIE  <= CSRWriteValM[3];
                STATUS_SIE  <= CSRWriteValM[1] & S_SUPPORTED;
                STATUS_SPIE <= CSRWriteValM[5] & S_SUPPORTED;
                STATUS_MPIE <= CSRWriteValM[7];
                STATUS_SPP  <= CSRWriteValM[8] & S_SUPPORTED;
                if (mppLegal) STATUS_MPP <= wrMpp;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        wfiState <= Run;
        else if (!StallW)  wfiState <= wfiNext;
    end

    // Any pending interrupt wakes the core, even one that is not enabled to trap.
    always_comb begin
        wfiNext = wfiState;
        case (wfiState)
            Run:   if (dec.wfiM & ~trapM) wfiNext = Sleep;
            Sleep: if ((|dec.InterruptPendingM) | trapM) wfiNext = Run;
        endcase
    end

    always_comb begin
        wfiTimeout = 1'b0;
        if (wfiState == Sleep)
            wfiTimeout = wfiCount[WFI_TIMEOUT_BIT] & ~(|dec.InterruptPendingM) &
                         ((STATUS_TW & (PrivilegeModeW != PRIV_M)) |
                          (S_SUPPORTED & (PrivilegeModeW == PRIV_U)));
        wfiStall = (wfiState == Sleep) & ~wfiTimeout;
    end

    // Held at zero while running so each sleep starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wfiCount <= '0;
        end else if (!StallW) begin
            if (wfiState == Run)                  wfiCount <= '0;
            else if (!wfiCount[WFI_TIMEOUT_BIT])  wfiCount <= wfiCount + {{WFI_TIMEOUT_BIT{1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_trap_ret_seq.sv
// Bench for trap_ret_seq: directed scenarios plus randomized traffic against a behavioural model.
module tb_trap_ret_seq;
    localparam int         TO_BIT         = 3;
    localparam int         TIMEOUT_CYCLES = 1 << TO_BIT;
    localparam logic [1:0] PU = 2'b00, PS = 2'b01, PM = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        StallW;
    logic [15:0] MEDELEG;
    logic [11:0] MIDELEG;
    logic        STATUS_TW, WriteMSTATUSM;
    logic [12:0] CSRWriteValM;
    logic [1:0]  PrivilegeModeW, STATUS_MPP;
    logic        STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP;

    trap_ret_seq_if io();

    trap_ret_seq #(.S_SUPPORTED(1'b1), .U_SUPPORTED(1'b1), .WFI_TIMEOUT_BIT(TO_BIT)) dut (
        .clk(clk), .reset(reset), .StallW(StallW), .dec(io),
        .MEDELEG(MEDELEG), .MIDELEG(MIDELEG), .STATUS_TW(STATUS_TW),
        .WriteMSTATUSM(WriteMSTATUSM), .CSRWriteValM(CSRWriteValM),
        .PrivilegeModeW(PrivilegeModeW), .STATUS_MIE(STATUS_MIE), .STATUS_SIE(STATUS_SIE),
        .STATUS_MPIE(STATUS_MPIE), .STATUS_SPIE(STATUS_SPIE), .STATUS_SPP(STATUS_SPP),
        .STATUS_MPP(STATUS_MPP)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    // Reference model state: architectural fields plus "asleep for N cycles".
    logic [1:0] mPriv, mMpp;
    bit         mMie, mSie, mMpie, mSpie, mSpp, mSleeping;
    int         mSleepCycles;

    wire [8:0] dutStat = {PrivilegeModeW, STATUS_MPP, STATUS_MIE, STATUS_SIE,
                          STATUS_MPIE, STATUS_SPIE, STATUS_SPP};

    function automatic logic [8:0] modelStat();
        return {mPriv, mMpp, mMie, mSie, mMpie, mSpie, mSpp};
    endfunction

    task automatic model_reset();
        mPriv = PM; mMpp = PU;
        mMie = 0; mSie = 0; mMpie = 0; mSpie = 0; mSpp = 0;
        mSleeping = 0; mSleepCycles = 0;
    endtask

    function automatic void model_comb(output bit trap, output bit intr, output int cause,
                                       output bit toS, output bit stall);
        int order [6] = '{11, 3, 7, 9, 1, 5};
        bit timeout;
        trap = 0; intr = 0; cause = 0; toS = 0;
        for (int k = 0; k < 6; k++) begin
            int n;
            bit ok;
            n = order[k];
            if (MIDELEG[n]) ok = (mPriv == PU) || (mPriv == PS && mSie);
            else            ok = (mPriv != PM) || mMie;
            if (!trap && io.InterruptPendingM[n] && ok) begin
                trap = 1; intr = 1; cause = n;
            end
        end
        timeout = mSleeping && (mSleepCycles >= TIMEOUT_CYCLES) && (io.InterruptPendingM == 0) &&
                  ((STATUS_TW && mPriv != PM) || mPriv == PU);
        if (!trap) begin
            if (io.BreakpointFaultM) begin trap = 1; cause = 3; end
            else if (io.IllegalInstrFaultM || timeout) begin trap = 1; cause = 2; end
            else if (io.EcallFaultM) begin trap = 1; cause = 8 + int'(mPriv); end
        end
        if (trap && mPriv != PM) toS = intr ? MIDELEG[cause] : MEDELEG[cause];
        stall = mSleeping && !timeout;
    endfunction

    task automatic tick();
        bit t, i, s, st;
        int c;
        model_comb(t, i, c, s, st);
        @(posedge clk);
        if (!StallW) begin
            if (t && s) begin
                mSpp = mPriv[0]; mSpie = mSie; mSie = 0; mPriv = PS;
            end else if (t) begin
                mMpp = mPriv; mMpie = mMie; mMie = 0; mPriv = PM;
            end else if (io.mretM) begin
                mPriv = mMpp; mMie = mMpie; mMpie = 1; mMpp = PU;
            end else if (io.sretM) begin
                mPriv = {1'b0, mSpp}; mSie = mSpie; mSpie = 1; mSpp = 0;
            end else if (WriteMSTATUSM) begin
                mMie = CSRWriteValM[3]; mSie = CSRWriteValM[1]; mSpie = CSRWriteValM[5];
                mMpie = CSRWriteValM[7]; mSpp = CSRWriteValM[8];
                if (CSRWriteValM[12:11] != 2'b10) mMpp = CSRWriteValM[12:11];
            end
            if (!mSleeping) begin
                if (io.wfiM && !t) begin mSleeping = 1; mSleepCycles = 0; end
            end else if (io.InterruptPendingM != 0 || t) begin
                mSleeping = 0;
            end else begin
                mSleepCycles++;
            end
        end
        #1;
    endtask

    task automatic idle();
        StallW = 0; STATUS_TW = 0; WriteMSTATUSM = 0; CSRWriteValM = '0;
        MEDELEG = '0; MIDELEG = '0;
        io.EcallFaultM = 0; io.BreakpointFaultM = 0; io.IllegalInstrFaultM = 0;
        io.mretM = 0; io.sretM = 0; io.wfiM = 0; io.InterruptPendingM = '0;
    endtask

    task automatic csr_write(input logic [12:0] v);
        WriteMSTATUSM = 1; CSRWriteValM = v;
        tick();
        WriteMSTATUSM = 0; CSRWriteValM = '0;
    endtask

    task automatic do_mret();
        io.mretM = 1; tick(); io.mretM = 0;
    endtask

    task automatic test_reset();
        idle(); model_reset(); reset = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        nTests++; if (PrivilegeModeW !== PM) begin nFail++; $display("FAIL reset_priv: got %b want 11", PrivilegeModeW); end
        nTests++; if ({STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP} !== 5'b0) begin nFail++; $display("FAIL reset_ie_bits: got %b want 00000", {STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP}); end
        nTests++; if (STATUS_MPP !== PU) begin nFail++; $display("FAIL reset_mpp: got %b want 00", STATUS_MPP); end
        nTests++; if ({io.WFIStallM, io.TrapM} !== 2'b00) begin nFail++; $display("FAIL reset_stall_trap: got %b want 00", {io.WFIStallM, io.TrapM}); end
    endtask

    task automatic test_ecall_m();
        io.EcallFaultM = 1;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.InterruptM, io.CauseM, io.TrapToSM} !== {1'b1, 1'b0, 4'd11, 1'b0}) begin nFail++; $display("FAIL ecall_m_comb: got %b want 1010110", {io.TrapM, io.InterruptM, io.CauseM, io.TrapToSM}); end
        tick(); idle();
        nTests++; if ({PrivilegeModeW, STATUS_MPP, STATUS_MIE} !== 5'b11110) begin nFail++; $display("FAIL ecall_m_state: got %b want 11110", {PrivilegeModeW, STATUS_MPP, STATUS_MIE}); end
    endtask

    task automatic test_mret();
        csr_write(13'h0080);
        do_mret();
        nTests++; if ({PrivilegeModeW, STATUS_MIE, STATUS_MPIE, STATUS_MPP} !== 6'b001100) begin nFail++; $display("FAIL mret_state: got %b want 001100", {PrivilegeModeW, STATUS_MIE, STATUS_MPIE, STATUS_MPP}); end
    endtask

    task automatic test_deleg_ecall();
        MEDELEG = 16'h0100; io.EcallFaultM = 1;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.CauseM, io.TrapToSM} !== {1'b1, 4'd8, 1'b1}) begin nFail++; $display("FAIL deleg_ecall_comb: got %b want 110001", {io.TrapM, io.CauseM, io.TrapToSM}); end
        tick(); idle();
        nTests++; if ({PrivilegeModeW, STATUS_SPP, STATUS_SIE} !== 4'b0100) begin nFail++; $display("FAIL deleg_ecall_state: got %b want 0100", {PrivilegeModeW, STATUS_SPP, STATUS_SIE}); end
        io.sretM = 1; tick(); idle();
        nTests++; if ({PrivilegeModeW, STATUS_SPIE} !== 3'b001) begin nFail++; $display("FAIL sret_state: got %b want 001", {PrivilegeModeW, STATUS_SPIE}); end
    endtask

    task automatic test_int_priority();
        io.EcallFaultM = 1;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.CauseM, io.TrapToSM} !== {1'b1, 4'd8, 1'b0}) begin nFail++; $display("FAIL ecall_u_to_m: got %b want 110000", {io.TrapM, io.CauseM, io.TrapToSM}); end
        tick(); idle();
        csr_write(13'h0800);
        do_mret();
        nTests++; if ({PrivilegeModeW, STATUS_MIE} !== 3'b010) begin nFail++; $display("FAIL enter_s: got %b want 010", {PrivilegeModeW, STATUS_MIE}); end
        io.InterruptPendingM = 12'h820; MIDELEG = 12'h020;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.InterruptM, io.CauseM, io.TrapToSM} !== {1'b1, 1'b1, 4'd11, 1'b0}) begin nFail++; $display("FAIL int_select_s: got %b want 1110110", {io.TrapM, io.InterruptM, io.CauseM, io.TrapToSM}); end
        tick();
        nTests++; if ({PrivilegeModeW, STATUS_MIE} !== 3'b110) begin nFail++; $display("FAIL int_to_m_state: got %b want 110", {PrivilegeModeW, STATUS_MIE}); end
        io.InterruptPendingM = 12'h0A0;
        @(negedge clk);
        nTests++; if (io.TrapM !== 1'b0) begin nFail++; $display("FAIL int_masked_m: got %b want 0", io.TrapM); end
        tick(); idle();
    endtask

    task automatic test_wfi_timeout();
        int stallCycles;
        bit done;
        stallCycles = 0; done = 0;
        csr_write(13'h0000);
        do_mret();
        io.wfiM = 1;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.WFIStallM} !== 2'b00) begin nFail++; $display("FAIL wfi_issue: got %b want 00", {io.TrapM, io.WFIStallM}); end
        tick(); io.wfiM = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (io.WFIStallM === 1'b1) begin stallCycles++; tick(); end
            else done = 1;
        end
        nTests++; if (!done) begin nFail++; $display("FAIL wfi_timeout_bound: stall still high after %0d cycles", stallCycles); end
        nTests++; if (stallCycles != TIMEOUT_CYCLES) begin nFail++; $display("FAIL wfi_stall_len: got %0d want %0d", stallCycles, TIMEOUT_CYCLES); end
        nTests++; if ({io.TrapM, io.InterruptM, io.CauseM} !== {1'b1, 1'b0, 4'd2}) begin nFail++; $display("FAIL wfi_timeout_trap: got %b want 100010", {io.TrapM, io.InterruptM, io.CauseM}); end
        tick();
        nTests++; if ({PrivilegeModeW, io.WFIStallM} !== 3'b110) begin nFail++; $display("FAIL wfi_after_timeout: got %b want 110", {PrivilegeModeW, io.WFIStallM}); end
    endtask

    task automatic test_wfi_wake_m();
        io.wfiM = 1; tick(); io.wfiM = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            nTests++; if (io.WFIStallM !== 1'b1) begin nFail++; $display("FAIL wfi_m_sleep%0d: got %b want 1", k, io.WFIStallM); end
            tick();
        end
        io.InterruptPendingM = 12'h080;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.WFIStallM} !== 2'b01) begin nFail++; $display("FAIL wfi_wake_edge: got %b want 01", {io.TrapM, io.WFIStallM}); end
        tick();
        @(negedge clk);
        nTests++; if ({io.TrapM, io.WFIStallM} !== 2'b00) begin nFail++; $display("FAIL wfi_woken: got %b want 00", {io.TrapM, io.WFIStallM}); end
        tick(); idle();
    endtask

    task automatic test_misc();
        io.BreakpointFaultM = 1; io.IllegalInstrFaultM = 1;
        @(negedge clk);
        nTests++; if ({io.TrapM, io.InterruptM, io.CauseM} !== {1'b1, 1'b0, 4'd3}) begin nFail++; $display("FAIL bp_over_illegal: got %b want 100011", {io.TrapM, io.InterruptM, io.CauseM}); end
        tick(); idle();
        csr_write(13'h0808);
        StallW = 1; io.EcallFaultM = 1;
        tick(); idle();
        nTests++; if (dutStat !== modelStat()) begin nFail++; $display("FAIL stall_hold: got %b want %b", dutStat, modelStat()); end
        nTests++; if ({PrivilegeModeW, STATUS_MPP, STATUS_MIE} !== 5'b11011) begin nFail++; $display("FAIL stall_fields: got %b want 11011", {PrivilegeModeW, STATUS_MPP, STATUS_MIE}); end
    endtask

    task automatic test_reset_mid_sleep();
        csr_write(13'h0000);
        do_mret();
        io.wfiM = 1; tick(); io.wfiM = 0;
        repeat (3) tick();
        nTests++; if ({PrivilegeModeW, io.WFIStallM} !== 3'b001) begin nFail++; $display("FAIL pre_reset_sleep: got %b want 001", {PrivilegeModeW, io.WFIStallM}); end
        #2 reset = 0;
        #1;
        nTests++; if ({PrivilegeModeW, io.WFIStallM} !== 3'b110) begin nFail++; $display("FAIL mid_sleep_reset: got %b want 110", {PrivilegeModeW, io.WFIStallM}); end
        model_reset();
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n);
        bit t, i, s, st;
        int c;
        for (int k = 0; k < n; k++) begin
            idle();
            StallW    = ($urandom_range(0, 9) == 0);
            MEDELEG   = 16'($urandom);
            MIDELEG   = 12'($urandom);
            STATUS_TW = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                io.InterruptPendingM = 12'($urandom) & 12'($urandom) & 12'($urandom);
            case ($urandom_range(0, 9))
                0: io.EcallFaultM = 1;
                1: io.BreakpointFaultM = 1;
                2: io.IllegalInstrFaultM = 1;
                3: begin io.BreakpointFaultM = 1; io.IllegalInstrFaultM = 1; io.EcallFaultM = 1; end
                4: if (mPriv == PM) io.mretM = 1;
                5: if (mPriv != PU) io.sretM = 1;
                6, 7: io.wfiM = 1;
                8: begin WriteMSTATUSM = 1; CSRWriteValM = 13'($urandom); end
                default: ;
            endcase
            @(negedge clk);
            model_comb(t, i, c, s, st);
            nTests++; if (io.TrapM !== t) begin nFail++; $display("FAIL rnd%0d_trap: got %b want %b", k, io.TrapM, t); end
            if (t) begin
                nTests++; if ({io.InterruptM, io.CauseM, io.TrapToSM} !== {i, 4'(c), s}) begin nFail++; $display("FAIL rnd%0d_cause: got %b want %b", k, {io.InterruptM, io.CauseM, io.TrapToSM}, {i, 4'(c), s}); end
            end
            nTests++; if (io.WFIStallM !== st) begin nFail++; $display("FAIL rnd%0d_stall: got %b want %b", k, io.WFIStallM, st); end
            tick();
            nTests++; if (dutStat !== modelStat()) begin nFail++; $display("FAIL rnd%0d_state: got %b want %b", k, dutStat, modelStat()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_ecall_m();
        test_mret();
        test_deleg_ecall();
        test_int_priority();
        test_wfi_timeout();
        test_wfi_wake_m();
        test_misc();
        test_reset_mid_sleep();
        test_random(400);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end
endmodule

// File: doc/trap_ret_seq.md
Name: trap_ret_seq

Overview:
- Privilege-state sequencer on the consuming side of the privileged-instruction decoder.
- Takes the decoded fault flags, return strobes, WFI strobe and pending interrupts.
- Selects the trap with a fixed priority, encodes its cause and resolves delegation.
- Owns the privilege mode and the mstatus/sstatus trap-stack fields, applies mret/sret unwinding, and runs the WFI sleep/timeout state machine.

Parameters:
- S_SUPPORTED, 1, supervisor mode implemented
- U_SUPPORTED, 1, user mode implemented
- WFI_TIMEOUT_BIT, 16, WFI timeout counter MSB index; counter width is WFI_TIMEOUT_BIT+1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- StallW  in  1  suppresses all state updates this cycle
- EcallFaultM  in  1  ecall in M stage
- BreakpointFaultM  in  1  ebreak in M stage
- IllegalInstrFaultM  in  1  illegal instruction in M stage
- mretM  in  1  legal mret
- sretM  in  1  legal sret
- wfiM  in  1  wfi instruction
- InterruptPendingM  in  12  mip & mie, bit index = interrupt code
- MEDELEG  in  16  exception delegation
- MIDELEG  in  12  interrupt delegation
- STATUS_TW  in  1  timeout-wait bit
- WriteMSTATUSM  in  1  CSR write to mstatus
- CSRWriteValM  in  13  write data bits [12:0]
- TrapM  out  1  trap taken this cycle (combinational)
- InterruptM  out  1  trap is an interrupt (combinational)
- CauseM  out  4  cause code (combinational)
- TrapToSM  out  1  trap delegated to S (combinational)
- PrivilegeModeW  out  2  current privilege (registered)
- STATUS_MIE, STATUS_SIE, STATUS_MPIE, STATUS_SPIE, STATUS_SPP  out  1 each  registered
- STATUS_MPP  out  2  registered
- WFIStallM  out  1  holds the pipeline while sleeping

Behaviour:
Reset (asynchronous, active-low):
- PrivilegeModeW=11, all IE/PIE bits=0, SPP=0.
- MPP=00 if U_SUPPORTED, else 11.
- WFI FSM=RUN, counter=0, WFIStallM=0.

Interrupt enable:
- Interrupt i is eligible if InterruptPendingM[i] is set and either:
  - not delegated: Priv!=M or MIE; or
  - delegated (MIDELEG[i] & S_SUPPORTED): Priv==U, or Priv==S & SIE.
- Delegated interrupts are never taken while Priv==M.
- Selection order among eligible interrupts: 11,3,7,9,1,5.

Trap priority: eligible interrupt > breakpoint (cause 3) > illegal or WFI timeout (cause 2) > ecall (cause 8 for U, 9 for S, 11 for M).

Delegation: TrapToSM = S_SUPPORTED & Priv!=M & deleg[CauseM], where deleg is MIDELEG for interrupts and MEDELEG for exceptions.

All state updates happen at the clock edge when ~StallW, in this precedence order:
- Trap to M: MPP<-Priv, MPIE<-MIE, MIE<-0, Priv<-M.
- Trap to S: SPP<-Priv[0], SPIE<-SIE, SIE<-0, Priv<-S.
- mret: Priv<-MPP, MIE<-MPIE, MPIE<-1, MPP<-(U_SUPPORTED ? 00 : 11).
- sret: Priv<-{0,SPP}, SIE<-SPIE, SPIE<-1, SPP<-0.
- mstatus write updates these fields: MIE[3], SIE[1], SPIE[5], MPIE[7], SPP[8], MPP[12:11].
  - A write of an unsupported MPP value (10, or a mode that is not implemented) retains the old MPP.
  - SIE/SPIE/SPP are tied 0 when !S_SUPPORTED.
- A trap suppresses a same-cycle ret or write.

WFI FSM:
- RUN -> SLEEP when wfiM & ~TrapM & ~StallW; counter cleared on entry.
- In SLEEP, WFIStallM=1 and the counter increments each cycle, saturating with the MSB set.
- SLEEP -> RUN when any InterruptPendingM bit is set, regardless of global enables. The wake is visible the next cycle; no trap unless the interrupt is eligible.
- SLEEP -> RUN and raise cause 2 when counter[MSB]=1 and ((STATUS_TW & Priv!=M) | (S_SUPPORTED & Priv==U)).
  - An interrupt arriving in the same cycle as the timeout wins.
- With Priv==M and no wake, SLEEP persists indefinitely.

Test Plan:
- Release reset, Priv=M, then ecallM -> TrapM=1, CauseM=11, TrapToSM=0. After the edge: Priv=11, MPP=11, MIE=0.
- mret in M with MPP=00, MPIE=1 -> next cycle Priv=00, MIE=1, MPIE=1, MPP=00.
- Priv=U, MEDELEG[8]=1, ecall -> CauseM=8, TrapToSM=1. Next cycle Priv=01, SPP=0, SIE=0. Then sret -> Priv=00, SPIE=1.
- Priv=S, InterruptPendingM bits 11 and 5 set, MIDELEG[5]=1, MIE=0 -> CauseM=11, InterruptM=1, TrapToSM=0. Priv=M, MIE=0, bits 5 and 7 -> no trap.
- WFI in U, WFI_TIMEOUT_BIT=3, no interrupts -> WFIStallM high 8 cycles, then TrapM with CauseM=2. In M mode with interrupt 7 pending after 3 cycles -> FSM returns to RUN, no timeout.
- Same-cycle breakpoint + illegal -> CauseM=3. StallW=1 with ecall -> no state change. Mid-SLEEP reset -> WFIStallM=0, Priv=11 immediately.
